// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared types and constants for the two-port RAM arbiter.
//   port_id_t  : identifies a requester (0 = instruction fetch, 1 = load/store)
//   LOCK_CNT_W : width of the burst-lock counter (LOCK_MAX is limited to 255)
package ram_port_arbiter_pkg;

   typedef logic port_id_t;

   localparam port_id_t PORT_IFU = 1'b0;
   localparam port_id_t PORT_LSU = 1'b1;

   localparam int LOCK_CNT_W = 8;

endpackage : ram_port_arbiter_pkg

// File: rtl/rr_lock_arbiter_2.sv
// rr_lock_arbiter_2
//   Two-requester round-robin arbiter with a bounded burst lock.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     req_i[1:0] : request per port
//     lock_i[1:0]: burst-ownership request per port
//     gnt_o[1:0] : one-hot grant, combinational from req_i (all zero in reset)
//     gnt_vld_o  : some port is granted this cycle
//     gnt_id_o   : id of the granted port (port 0 when nothing is granted)
module rr_lock_arbiter_2
   import ram_port_arbiter_pkg::*;
#(
   parameter int LOCK_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic [1:0] lock_i,
   output logic [1:0] gnt_o,
   output logic       gnt_vld_o,
   output port_id_t   gnt_id_o
);

   localparam logic [LOCK_CNT_W:0] LOCK_LIMIT = LOCK_MAX[LOCK_CNT_W:0];

   port_id_t              rr_ptr_q, rr_ptr_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [LOCK_CNT_W:0]   cnt_base;
   logic [LOCK_CNT_W:0]   cnt_inc;

   // Grant selection: a lone requester always wins, a tie goes to rr_ptr.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_id_o  = PORT_IFU;
      if (!rst) begin
         unique case (req_i)
            2'b01:   begin gnt_vld_o = 1'b1; gnt_id_o = PORT_IFU; end
            2'b10:   begin gnt_vld_o = 1'b1; gnt_id_o = PORT_LSU; end
            2'b11:   begin gnt_vld_o = 1'b1; gnt_id_o = rr_ptr_q; end
            default: begin gnt_vld_o = 1'b0; gnt_id_o = PORT_IFU; end
         endcase
      end
      gnt_o = 2'b00;
      if (gnt_vld_o) gnt_o[gnt_id_o] = 1'b1;
   end

   // Pointer/lock update. A non-zero lock_cnt means rr_ptr names the port
   // that owns the current burst, so a grant to the other port restarts the
   // count from zero. The +1 is done one bit wider so LOCK_MAX=255 is safe.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      cnt_base   = (rr_ptr_q == gnt_id_o) ? {1'b0, lock_cnt_q} : '0;
      cnt_inc    = cnt_base + 1'b1;
      if (gnt_vld_o) begin
         if (lock_i[gnt_id_o] && (cnt_inc < LOCK_LIMIT)) begin
            rr_ptr_d   = gnt_id_o;
            lock_cnt_d = cnt_inc[LOCK_CNT_W-1:0];
         end else begin
            rr_ptr_d   = ~gnt_id_o;
            lock_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= PORT_IFU;
         lock_cnt_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

endmodule : rr_lock_arbiter_2

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM (1-cycle read latency, write-first
//   readout) between two requesters and routes each response back.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     mN_req/we/lock/addr/wdata : request side of port N (N = 0, 1)
//     mN_gnt                : request accepted this cycle (combinational)
//     mN_rvalid/rdata       : response, exactly one cycle after mN_gnt
//     ram_en/we/addr/di     : RAM command, muxed from the granted port
//     ram_dout              : RAM data, valid one cycle after ram_en
//
//   Handshake: a requester raises mN_req with stable we/addr/wdata and keeps
//   them until mN_gnt is high in the same cycle; that cycle is the transfer.
//   Every transfer (read or write) yields one mN_rvalid pulse the next cycle;
//   responses cannot be back-pressured.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int AW       = 10,
   parameter int LOCK_MAX = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic             m0_lock,
   input  logic [AW-1:0]    m0_addr,
   input  logic [WIDTH-1:0] m0_wdata,
   output logic             m0_gnt,
   output logic             m0_rvalid,
   output logic [WIDTH-1:0] m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic             m1_lock,
   input  logic [AW-1:0]    m1_addr,
   input  logic [WIDTH-1:0] m1_wdata,
   output logic             m1_gnt,
   output logic             m1_rvalid,
   output logic [WIDTH-1:0] m1_rdata,
   output logic             ram_en,
   output logic             ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [WIDTH-1:0] ram_di,
   input  logic [WIDTH-1:0] ram_dout
);

   logic [1:0] gnt;
   logic       gnt_vld;
   port_id_t   gnt_id;
   logic       sel_lsu;

   logic       resp_vld_q, resp_vld_d;
   port_id_t   resp_id_q, resp_id_d;

   rr_lock_arbiter_2 #(
      .LOCK_MAX (LOCK_MAX)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     ({m1_req, m0_req}),
      .lock_i    ({m1_lock, m0_lock}),
      .gnt_o     (gnt),
      .gnt_vld_o (gnt_vld),
      .gnt_id_o  (gnt_id)
   );

   assign m0_gnt = gnt[PORT_IFU];
   assign m1_gnt = gnt[PORT_LSU];
   assign ram_en = gnt_vld;

   // With no grant the address/data follow port 0; only ram_we is gated.
   assign sel_lsu  = gnt_vld && (gnt_id == PORT_LSU);
   assign ram_we   = gnt_vld && (sel_lsu ? m1_we : m0_we);
   assign ram_addr = sel_lsu ? m1_addr  : m0_addr;
   assign ram_di   = sel_lsu ? m1_wdata : m0_wdata;

   always_comb begin
      resp_vld_d = gnt_vld;
      resp_id_d  = gnt_vld ? gnt_id : resp_id_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld_q <= 1'b0;
         resp_id_q  <= PORT_IFU;
      end else begin
         resp_vld_q <= resp_vld_d;
         resp_id_q  <= resp_id_d;
      end
   end

   // rdata comes straight from the RAM; it is zeroed when the port has no
   // response so the idle/reset value is deterministic.
   assign m0_rvalid = resp_vld_q && (resp_id_q == PORT_IFU);
   assign m1_rvalid = resp_vld_q && (resp_id_q == PORT_LSU);
   assign m0_rdata  = m0_rvalid ? ram_dout : '0;
   assign m1_rdata  = m1_rvalid ? ram_dout : '0;

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int WIDTH    = 32;
  localparam int AW       = 10;
  localparam int LOCK_MAX = 8;
  localparam int DEPTH    = 1 << AW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [AW-1:0]    m0_addr = '0;
  logic [WIDTH-1:0] m0_wdata = '0;
  logic             m0_gnt, m0_rvalid;
  logic [WIDTH-1:0] m0_rdata;
  logic             m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0]    m1_addr = '0;
  logic [WIDTH-1:0] m1_wdata = '0;
  logic             m1_gnt, m1_rvalid;
  logic [WIDTH-1:0] m1_rdata;
  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_di;
  logic [WIDTH-1:0] ram_dout = '0;

  ram_port_arbiter #(.WIDTH(WIDTH), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  // ---------------- clock / RAM environment ----------------
  always #5 clk = ~clk;

  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_di;
        ram_dout          <= ram_di;
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  // entry = {valid, port, data}
  logic [WIDTH+1:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rr_m = 1'b0;
  logic owner_m = 1'b0;
  int   lcnt_m = 0;
  logic obs_g0, obs_g1;
  int   rv1_cnt = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr_m    = 1'b0;
    owner_m = 1'b0;
    lcnt_m  = 0;
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, check responses and grant, predict next.
  task automatic step(input logic r0, input logic w0, input logic l0,
                      input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    logic [WIDTH+1:0] exp;
    logic             gv, gid, lk, wr;
    logic [AW-1:0]    ad;
    logic [WIDTH-1:0] data;
    int               base;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("m0_rvalid", WIDTH'(m0_rvalid), WIDTH'(exp[WIDTH+1] && !exp[WIDTH]));
    chk("m1_rvalid", WIDTH'(m1_rvalid), WIDTH'(exp[WIDTH+1] && exp[WIDTH]));
    if (exp[WIDTH+1]) begin
      if (exp[WIDTH]) chk("m1_rdata", m1_rdata, exp[WIDTH-1:0]);
      else            chk("m0_rdata", m0_rdata, exp[WIDTH-1:0]);
    end
    if (m1_rvalid) rv1_cnt++;

    gv  = r0 | r1;
    gid = (r0 && r1) ? rr_m : !r0;
    chk("m0_gnt", WIDTH'(m0_gnt), WIDTH'(gv && !gid));
    chk("m1_gnt", WIDTH'(m1_gnt), WIDTH'(gv && gid));
    chk("ram_en", WIDTH'(ram_en), WIDTH'(gv));
    obs_g0 = m0_gnt;
    obs_g1 = m1_gnt;

    if (gv) begin
      ad = gid ? a1 : a0;
      wr = gid ? w1 : w0;
      lk = gid ? l1 : l0;
      chk("ram_addr", WIDTH'(ram_addr), WIDTH'(ad));
      chk("ram_we", WIDTH'(ram_we), WIDTH'(wr));
      if (wr) begin
        data = gid ? d1 : d0;
        ref_mem[ad] = data;
      end else begin
        data = ref_mem[ad];
      end
      exp_q.push_back({1'b1, gid, data});
      base = (owner_m == gid) ? lcnt_m : 0;
      if (lk && (base + 1 < LOCK_MAX)) begin
        rr_m   = gid;
        lcnt_m = base + 1;
      end else begin
        rr_m   = !gid;
        lcnt_m = 0;
      end
      owner_m = gid;
    end else begin
      chk("ram_we_idle", WIDTH'(ram_we), '0);
      exp_q.push_back('0);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // Reset with both ports requesting so the forced-off grant is visible.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1; m1_req = 1;
    #1;
    chk("rst_m0_gnt", WIDTH'(m0_gnt), '0);
    chk("rst_m1_gnt", WIDTH'(m1_gnt), '0);
    chk("rst_ram_en", WIDTH'(ram_en), '0);
    chk("rst_m0_rvalid", WIDTH'(m0_rvalid), '0);
    chk("rst_m1_rvalid", WIDTH'(m1_rvalid), '0);
    chk("rst_m0_rdata", m0_rdata, '0);
    chk("rst_m1_rdata", m1_rdata, '0);
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0]    a0, a1;
    logic [WIDTH-1:0] v;
    int               run, g1_cnt, rv1_start;
    logic             hist1 [10];
    logic             hist0 [10];

    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram_mem[i] <= v;
      ref_mem[i] = v;
    end
    ram_mem[5] <= 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    do_reset();

    // Single read after reset
    step(1, 0, 0, 10'h005, '0, 0, 0, 0, '0, '0);
    idle();
    chk("first_read_data", m0_rdata, 32'hDEADBEEF);

    // Both ports reading continuously, no lock: alternation
    a0 = AW'($urandom_range(0, DEPTH - 1));
    a1 = AW'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, a0, '0, 1, 0, 0, a1, '0);
      if (obs_g0) a0 = AW'($urandom_range(0, DEPTH - 1));
      if (obs_g1) a1 = AW'($urandom_range(0, DEPTH - 1));
    end
    idle();

    // m0 burst lock against a continuously requesting m1
    do_reset();
    a0 = AW'($urandom_range(0, DEPTH - 1));
    a1 = AW'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, a0, '0, 1, 0, 0, a1, '0);
      hist0[i] = obs_g0;
      hist1[i] = obs_g1;
      if (obs_g0) a0 = AW'($urandom_range(0, DEPTH - 1));
      if (obs_g1) a1 = AW'($urandom_range(0, DEPTH - 1));
    end
    idle();
    run = 0;
    for (int i = 0; i < 10; i++) begin
      if (hist0[i] && run == i) run++;
    end
    chk("lock_run", WIDTH'(run), WIDTH'(LOCK_MAX));
    chk("lock_yield_m1", WIDTH'(hist1[LOCK_MAX]), WIDTH'(1));
    chk("lock_resume_m0", WIDTH'(hist0[LOCK_MAX + 1]), WIDTH'(1));

    // Write from m1, immediately read back by m0
    step(0, 0, 0, '0, '0, 1, 1, 0, 10'h3FF, 32'h0000_0055);
    step(1, 0, 0, 10'h3FF, '0, 0, 0, 0, '0, '0);
    chk("wr_ack_data", m1_rdata, 32'h0000_0055);
    idle();
    chk("rd_after_wr", m0_rdata, 32'h0000_0055);

    // Reset in the cycle after an m0 grant: response discarded
    step(1, 0, 0, 10'h005, '0, 0, 0, 0, '0, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_m0_rvalid", WIDTH'(m0_rvalid), '0);
    @(negedge clk);
    chk("midrst_hold_rvalid", WIDTH'(m0_rvalid), '0);
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    rst = 1'b0;
    model_reset();
    idle();
    step(1, 0, 0, 10'h001, '0, 1, 0, 0, 10'h002, '0);
    chk("post_rst_m0_wins", WIDTH'(obs_g0), WIDTH'(1));
    idle();

    // m1 alone, 20 back-to-back mixed accesses
    g1_cnt = 0;
    rv1_start = rv1_cnt;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, '0, '0, 1, 1'($urandom_range(0, 1)), 0,
           AW'($urandom_range(0, DEPTH - 1)), $urandom);
      if (obs_g1) g1_cnt++;
    end
    idle();
    idle();
    chk("b2b_grants", WIDTH'(g1_cnt), WIDTH'(20));
    chk("b2b_rvalids", WIDTH'(rv1_cnt - rv1_start), WIDTH'(20));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_port_arbiter

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (one-cycle read latency, write-first readout) between two requesters, e.g. instruction fetch (port 0) and load/store (port 1) in the smartL core.
- Issues at most one RAM access per cycle and routes each read/write response back to the port that issued it.
- Arbitration is round-robin with an optional bounded burst lock.

Parameters:
- WIDTH, 32, data width of the RAM and of both ports.
- AW, 10, address width; the RAM holds 2**AW words.
- LOCK_MAX, 8, maximum consecutive grants to a locking port before it is forced to yield; range 1..255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  port 0 request; held stable until m0_gnt.
- m0_we  in  1  port 0 write enable (1 = write, 0 = read).
- m0_lock  in  1  port 0 requests burst ownership.
- m0_addr  in  AW  port 0 address.
- m0_wdata  in  WIDTH  port 0 write data.
- m0_gnt  out  1  port 0 request accepted this cycle.
- m0_rvalid  out  1  port 0 response valid.
- m0_rdata  out  WIDTH  port 0 response data.
- m1_*  same set as m0_*, for port 1.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_di  out  WIDTH  RAM write data.
- ram_dout  in  WIDTH  RAM read data, valid one cycle after ram_en.

Behaviour:
- Reset values:
  - rr_ptr = 0 (port 0 favoured), lock_cnt = 0, resp_vld = 0, resp_id = 0.
  - m0/m1_rvalid = 0 and rdata = 0.
  - While rst = 1: gnt outputs and ram_en are forced to 0.
- Grant (combinational, same cycle as request):
  - Only one requester: it is granted.
  - Both requesting: the port equal to rr_ptr wins.
  - At most one gnt is high per cycle. ram_en = m0_gnt | m1_gnt.
  - ram_we/addr/di are muxed from the granted port. When there is no grant: ram_we = 0 and addr/di hold port 0 values (don't care).
- Pointer update, on any grant to port g:
  - If mg_lock = 1 and lock_cnt + 1 < LOCK_MAX: rr_ptr = g and lock_cnt increments.
  - Otherwise: rr_ptr = ~g and lock_cnt = 0.
  - A grant to the other port clears lock_cnt. With no grant, rr_ptr and lock_cnt hold.
- A locking port with continuous requests therefore receives exactly LOCK_MAX consecutive grants, then the other port, if requesting, wins the next arbitration.
- Response pipeline:
  - On each grant, resp_vld <= 1 and resp_id <= g; otherwise resp_vld <= 0.
  - Next cycle: m{resp_id}_rvalid = resp_vld and m{resp_id}_rdata = ram_dout. The other port's rvalid = 0.
  - rdata is driven straight from ram_dout, not re-registered. Latency from gnt to rvalid is exactly 1 cycle.
  - Writes also return rvalid (write acknowledge) with rdata = written data, per the RAM's write-first readout.
- Back-to-back operation: a new grant may occur in the same cycle as the previous rvalid. Throughput is 1 access per cycle.
- Boundaries:
  - Address wrap is the RAM's concern; addresses pass through unmodified.
  - A req dropped before gnt is a protocol violation; no assertion is required in RTL. The bench checks it.
  - Reset asserted mid-transaction: the in-flight response is discarded and rvalid stays 0 after release.
  - lock_cnt saturates logic: never exceeds LOCK_MAX-1.
  - LOCK_MAX = 1 gives pure round-robin.

Decomposition:
- Shared package: port id type (1 bit) and the constants PORT_IFU = 0, PORT_LSU = 1.
- One natural sub-module: rr_lock_arbiter_2, holding rr_ptr, lock_cnt and the grant logic. The top contains the muxing and response pipeline.

Test Plan:
- Reset release, m0 read addr 0x005 (RAM preloaded 0xDEADBEEF) -> m0_gnt in the same cycle, m0_rvalid = 1 and m0_rdata = 0xDEADBEEF one cycle later, m1_rvalid = 0.
- Both ports request reads continuously, lock = 0 -> grants alternate 0,1,0,1…; every rvalid goes to the correct port with data from its address.
- m0 holds lock = 1 with back-to-back requests, m1 requesting, LOCK_MAX = 8 -> m0 gets 8 consecutive grants, then m1 is granted on the 9th cycle.
- m1 write 0x00000055 to addr 0x3FF, then m0 read 0x3FF on the next cycle -> m1_rvalid with rdata 0x55, then m0_rvalid with rdata 0x55 (no stale data).
- rst asserted in the cycle after an m0 grant -> no m0_rvalid ever appears for that transaction; after release, rr_ptr = 0 (simultaneous requests grant m0).
- Single requester m1 issuing 20 back-to-back accesses with m0 idle -> 20 consecutive grants and 20 rvalids, each one cycle later, with no bubbles.
